// File: rtl/b_port_calc_pkg.sv
// Shared B-port definitions: operation codes, calculator state encoding and
// helpers used by both the calculator and the B-port consumer.
package b_port_calc_pkg;

    localparam int DATA_W = 32;
    localparam int DONE_W = 16;
    localparam int CNT_W  = 5;

    typedef enum logic [2:0] {
        OP_ADD2 = 3'd0,
        OP_SUB2 = 3'd1,
        OP_OR2  = 3'd2,
        OP_AND2 = 3'd3,
        OP_OR   = 3'd4,
        OP_AND  = 3'd5,
        OP_SUM  = 3'd6,
        OP_AVG  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RESULT  = 2'd2
    } state_e;

    // Codes 4-7 reduce over NUM_RED operands; codes 0-3 take exactly two.
    function automatic logic op_is_red(input op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/b_port_calc.sv
// Operand-collecting calculator: gathers 2 or NUM_RED operands on the A port,
// combines them per the latched opcode, and presents one result on the B port.
module b_port_calc
    import b_port_calc_pkg::*;
#(
    parameter int NUM_RED = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  a_valid,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  a_ready,
    input  logic [2:0]            b_operation,
    output logic                  b_valid,
    output logic [DATA_W-1:0]     b_result,
    input  logic                  b_ready,
    output logic [DONE_W-1:0]     done_count
);

    localparam int LOG2_RED = $clog2(NUM_RED);
    // Extra headroom so AVG can divide the untruncated sum.
    localparam int ACC_W = DATA_W + LOG2_RED;
    localparam logic [CNT_W-1:0] RED_CNT = CNT_W'(NUM_RED);
    localparam logic [CNT_W-1:0] PAIR_CNT = CNT_W'(2);

    state_e             state;
    op_e                op;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic [ACC_W-1:0]   nxt_acc;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   need;
    logic               a_hs;
    logic               b_hs;

    function automatic logic [ACC_W-1:0] combine(input op_e o,
                                                 input logic [ACC_W-1:0] a,
                                                 input logic [DATA_W-1:0] d);
        logic [ACC_W-1:0] r;
        case (o)
            OP_ADD2, OP_SUM, OP_AVG: r = a + ACC_W'(d);
            OP_SUB2:                 r = ACC_W'(a[DATA_W-1:0] - d);
            OP_OR2, OP_OR:           r = ACC_W'(a[DATA_W-1:0] | d);
            default:                 r = ACC_W'(a[DATA_W-1:0] & d);
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] finalize(input op_e o,
                                                   input logic [ACC_W-1:0] a);
        logic [DATA_W-1:0] r;
        if (o == OP_AVG)
            r = DATA_W'(a >> LOG2_RED);
        else
            r = a[DATA_W-1:0];
        return r;
    endfunction

    assign a_hs    = a_valid && a_ready;
    assign b_hs    = b_valid && b_ready;
    assign nxt_acc = combine(op, acc, a_data);
    assign cnt_inc = cnt + CNT_W'(1);
    assign need    = op_is_red(op) ? RED_CNT : PAIR_CNT;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            op         <= OP_OR;
            acc        <= '0;
            cnt        <= '0;
            a_ready    <= 1'b1;
            b_valid    <= 1'b0;
            b_result   <= '0;
            done_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (a_hs) begin
                        op    <= op_e'(b_operation);
                        acc   <= ACC_W'(a_data);
                        cnt   <= CNT_W'(1);
                        state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (a_hs) begin
                        acc <= nxt_acc;
                        cnt <= cnt_inc;
                        if (cnt_inc == need) begin
                            state    <= ST_RESULT;
                            a_ready  <= 1'b0;
                            b_valid  <= 1'b1;
                            b_result <= finalize(op, nxt_acc);
                        end
                    end
                end
                ST_RESULT: begin
                    // a_ready is low here, so no operand can slip in on the B handshake.
                    if (b_hs) begin
                        state      <= ST_IDLE;
                        a_ready    <= 1'b1;
                        b_valid    <= 1'b0;
                        done_count <= done_count + DONE_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    a_ready <= 1'b1;
                    b_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b_port_calc.sv
// Directed bench for b_port_calc with NUM_RED=4.
module tb_b_port_calc;

    logic        clk;
    logic        rstn;
    logic        a_valid;
    logic [31:0] a_data;
    logic        a_ready;
    logic [2:0]  b_operation;
    logic        b_valid;
    logic [31:0] b_result;
    logic        b_ready;
    logic [15:0] done_count;

    int passed = 0;
    int total  = 0;

    b_port_calc #(.NUM_RED(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_operation(b_operation),
        .b_valid    (b_valid),
        .b_result   (b_result),
        .b_ready    (b_ready),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand and hold it until accepted; returns #1 after the accepting edge.
    task automatic push(input logic [2:0] op, input logic [31:0] d);
        int n;
        n = 0;
        b_operation = op;
        a_data      = d;
        a_valid     = 1'b1;
        while (!a_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 20) $display("FAIL push_timeout: a_ready stayed 0, required 1");
        else passed++;
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    // Accept the pending result and check it along with the bookkeeping.
    task automatic pop(input string name, input logic [31:0] exp);
        logic [15:0] dc;
        dc = done_count;
        total++;
        if (b_valid !== 1'b1 || b_result !== exp)
            $display("FAIL %s: b_valid=%b b_result=%h, required b_valid=1 b_result=%h",
                     name, b_valid, b_result, exp);
        else passed++;
        b_ready = 1'b1;
        @(posedge clk); #1;
        b_ready = 1'b0;
        total++;
        if (b_valid !== 1'b0 || a_ready !== 1'b1 || done_count !== dc + 16'd1)
            $display("FAIL %s_retire: b_valid=%b a_ready=%b done_count=%0d, required 0 1 %0d",
                     name, b_valid, a_ready, done_count, dc + 16'd1);
        else passed++;
    endtask

    task automatic test_reset();
        rstn = 1'b0; a_valid = 1'b0; a_data = '0; b_operation = '0; b_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (a_ready !== 1'b1 || b_valid !== 1'b0 || b_result !== 32'h0 || done_count !== 16'h0)
            $display("FAIL reset: a_ready=%b b_valid=%b b_result=%h done_count=%0d, required 1 0 0 0",
                     a_ready, b_valid, b_result, done_count);
        else passed++;
        rstn = 1'b1;
    endtask

    task automatic test_add2();
        push(3'd0, 32'hFFFF_FFFF);
        total++;
        if (b_valid !== 1'b0 || a_ready !== 1'b1)
            $display("FAIL add2_collect: b_valid=%b a_ready=%b, required 0 1", b_valid, a_ready);
        else passed++;
        push(3'd0, 32'h0000_0002);
        pop("add2", 32'h0000_0001);
    endtask

    task automatic test_sub2();
        push(3'd1, 32'd5);
        push(3'd1, 32'd7);
        pop("sub2", 32'hFFFF_FFFE);
    endtask

    task automatic test_avg_sum();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i > 0 && b_valid !== 1'b0)
                $display("FAIL avg_early: b_valid=%b after %0d operands, required 0", b_valid, i);
            else passed++;
            push(3'd7, 32'hFFFF_FFFF);
        end
        pop("avg", 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) push(3'd6, 32'hFFFF_FFFF);
        pop("sum", 32'hFFFF_FFFC);
    endtask

    task automatic test_hold();
        logic [31:0] ops [4];
        int bad;
        ops[0] = 32'h1; ops[1] = 32'h2; ops[2] = 32'h4; ops[3] = 32'h8;
        for (int i = 0; i < 4; i++) push(3'd4, ops[i]);
        bad = 0;
        // Offer an extra operand while the result waits; it must not be taken.
        a_valid = 1'b1; a_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            if (b_valid !== 1'b1 || b_result !== 32'hF || a_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        total++;
        if (bad != 0)
            $display("FAIL or_hold: %0d unstable cycles, b_result=%h a_ready=%b, required 0 with F 0",
                     bad, b_result, a_ready);
        else passed++;
        pop("or_hold", 32'hF);
    endtask

    task automatic test_early_ready_stall();
        logic [15:0] dc;
        dc = done_count;
        push(3'd3, 32'hFF00_FF00);
        b_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        b_ready = 1'b0;
        total++;
        if (b_valid !== 1'b0 || done_count !== dc || a_ready !== 1'b1)
            $display("FAIL stall_early_ready: b_valid=%b done_count=%0d a_ready=%b, required 0 %0d 1",
                     b_valid, done_count, a_ready, dc);
        else passed++;
        push(3'd3, 32'h0FF0_0FF0);
        pop("and2_stall", 32'h0F00_0F00);
    endtask

    task automatic test_op_change();
        push(3'd3, 32'hF0F0_F0F0);
        push(3'd6, 32'hFF00_FF00);
        pop("op_change", 32'hF000_F000);
    endtask

    task automatic test_reset_mid();
        push(3'd6, 32'd100);
        push(3'd6, 32'd200);
        #2 rstn = 1'b0;
        #3;
        total++;
        if (b_valid !== 1'b0 || done_count !== 16'd0 || a_ready !== 1'b1)
            $display("FAIL reset_mid: b_valid=%b done_count=%0d a_ready=%b, required 0 0 1",
                     b_valid, done_count, a_ready);
        else passed++;
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) push(3'd6, 32'd10 + 32'(i));
        pop("sum_after_reset", 32'd46);
    endtask

    task automatic test_back_to_back();
        push(3'd2, 32'h0000_00F0);
        push(3'd2, 32'h0000_000F);
        pop("b2b_or2", 32'h0000_00FF);
        push(3'd5, 32'hFFFF_0000);
        push(3'd5, 32'hFF00_FF00);
        push(3'd5, 32'hF0F0_F0F0);
        push(3'd5, 32'hCCCC_CCCC);
        pop("b2b_and", 32'hC000_0000);
        push(3'd7, 32'd1);
        push(3'd7, 32'd2);
        push(3'd7, 32'd3);
        push(3'd7, 32'd4);
        pop("b2b_avg", 32'd2);
    endtask

    initial begin
        test_reset();
        test_add2();
        test_sub2();
        test_avg_sum();
        test_hold();
        test_early_ready_stall();
        test_op_change();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
